// File: rtl/uart_resp_collector.sv
`timescale 1ns/1ps
// uart_resp_collector: oversampled UART receiver with 3-sample majority vote, optional parity and
// LSB-first byte pairing into words. Define RESP_TIMEOUT_EN to flush stale half-words (adds TIMEOUT).
module uart_resp_collector #(
  parameter int DATA_WIDTH     = 8,
  parameter int WORD_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            PRESCALE,
  input  logic                  WORD_MODE,
  output logic [DATA_WIDTH-1:0] BYTE_OUT,
  output logic                  BYTE_VLD,
  output logic [WORD_WIDTH-1:0] WORD_OUT,
  output logic                  WORD_VLD,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic [7:0]            FRAME_CNT,
`ifdef RESP_TIMEOUT_EN
  output logic                  TIMEOUT,
`endif
  output logic                  BUSY
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  if (WORD_WIDTH != 2 * DATA_WIDTH || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("uart_resp_collector: WORD_WIDTH must equal 2*DATA_WIDTH and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_reg, state_next;
  logic                  rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [5:0]            edge_cnt_reg, edge_cnt_next;
  logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [2:0]            samp_reg, samp_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  par_bad_reg, par_bad_next;
  logic [5:0]            presc_reg, presc_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_typ_reg, par_typ_next;
  logic [DATA_WIDTH-1:0] low_reg, low_next;
  logic                  half_reg, half_next;
  logic [DATA_WIDTH-1:0] byte_out_reg, byte_out_next;
  logic [WORD_WIDTH-1:0] word_out_reg, word_out_next;
  logic [7:0]            frame_cnt_reg, frame_cnt_next;
  logic                  byte_vld_reg, byte_vld_next;
  logic                  word_vld_reg, word_vld_next;
  logic                  par_err_reg, par_err_next;
  logic                  stp_err_reg, stp_err_next;
`ifdef RESP_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CYCLES)-1:0] to_cnt_reg, to_cnt_next;
  logic                              timeout_reg, timeout_next;
`endif

  logic       rx_fall;
  logic [5:0] presc_sel;
  logic [5:0] bit_half;
  logic [5:0] bit_last;
  logic       resolve;
  logic       bit_end;
  logic       bit_val;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= RX_IN;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  assign rx_fall  = rx_prev_reg & ~rx_sync_reg;
  assign bit_half = {1'b0, presc_reg[5:1]};
  assign bit_last = presc_reg - 6'd1;
  assign resolve  = (edge_cnt_reg == bit_half + 6'd2);
  assign bit_end  = (edge_cnt_reg == bit_last);
  assign bit_val  = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & samp_reg[2]) |
                    (samp_reg[1] & samp_reg[2]);

  always_comb begin
    case (PRESCALE)
      6'd16:   presc_sel = 6'd16;
      6'd32:   presc_sel = 6'd32;
      default: presc_sel = 6'd8;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    edge_cnt_next  = edge_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    samp_next      = samp_reg;
    shift_next     = shift_reg;
    par_bad_next   = par_bad_reg;
    presc_next     = presc_reg;
    par_en_next    = par_en_reg;
    par_typ_next   = par_typ_reg;
    low_next       = low_reg;
    half_next      = half_reg & WORD_MODE;
    byte_out_next  = byte_out_reg;
    word_out_next  = word_out_reg;
    frame_cnt_next = frame_cnt_reg;
    byte_vld_next  = 1'b0;
    word_vld_next  = 1'b0;
    par_err_next   = 1'b0;
    stp_err_next   = 1'b0;
`ifdef RESP_TIMEOUT_EN
    to_cnt_next    = '0;
    timeout_next   = 1'b0;
`endif

    if (state_reg != IDLE) begin
      edge_cnt_next = bit_end ? 6'd0 : edge_cnt_reg + 6'd1;
      if (edge_cnt_reg == bit_half - 6'd1) samp_next[0] = rx_sync_reg;
      if (edge_cnt_reg == bit_half)        samp_next[1] = rx_sync_reg;
      if (edge_cnt_reg == bit_half + 6'd1) samp_next[2] = rx_sync_reg;
    end

    case (state_reg)
      IDLE: begin
        // The detection cycle is sample 0 of the start bit, so counting resumes at 1.
        if (rx_fall) begin
          state_next    = START;
          edge_cnt_next = 6'd1;
          presc_next    = presc_sel;
          par_en_next   = PAR_EN;
          par_typ_next  = PAR_TYP;
          par_bad_next  = 1'b0;
        end
      end
      START: begin
        if (resolve && bit_val) begin
          state_next    = IDLE;
          edge_cnt_next = 6'd0;
        end else if (bit_end) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (resolve) shift_next = {bit_val, shift_reg[DATA_WIDTH-1:1]};
        if (bit_end) begin
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          if (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1))
            state_next = par_en_reg ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (resolve) par_bad_next = (bit_val != ((^shift_reg) ^ par_typ_reg));
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        // Leave mid stop bit so a start edge right after the stop bit is not missed.
        if (resolve) begin
          state_next    = IDLE;
          edge_cnt_next = 6'd0;
          if (bit_val && !par_bad_reg) begin
            byte_out_next  = shift_reg;
            byte_vld_next  = 1'b1;
            frame_cnt_next = frame_cnt_reg + 8'd1;
            if (WORD_MODE) begin
              if (half_reg) begin
                word_out_next = {shift_reg, low_reg};
                word_vld_next = 1'b1;
                half_next     = 1'b0;
              end else begin
                low_next  = shift_reg;
                half_next = 1'b1;
              end
            end else begin
              half_next = 1'b0;
            end
          end else begin
            par_err_next = par_bad_reg;
            stp_err_next = ~bit_val;
            half_next    = 1'b0;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        edge_cnt_next = 6'd0;
      end
    endcase

`ifdef RESP_TIMEOUT_EN
    if (state_reg == IDLE && half_reg) begin
      if (to_cnt_reg == $bits(to_cnt_reg)'(TIMEOUT_CYCLES - 1)) begin
        word_out_next = {{DATA_WIDTH{1'b0}}, low_reg};
        word_vld_next = 1'b1;
        timeout_next  = 1'b1;
        half_next     = 1'b0;
      end else begin
        to_cnt_next = to_cnt_reg + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      edge_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      samp_reg      <= '0;
      shift_reg     <= '0;
      par_bad_reg   <= 1'b0;
      presc_reg     <= 6'd8;
      par_en_reg    <= 1'b0;
      par_typ_reg   <= 1'b0;
      low_reg       <= '0;
      half_reg      <= 1'b0;
      byte_out_reg  <= '0;
      word_out_reg  <= '0;
      frame_cnt_reg <= '0;
      byte_vld_reg  <= 1'b0;
      word_vld_reg  <= 1'b0;
      par_err_reg   <= 1'b0;
      stp_err_reg   <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      to_cnt_reg    <= '0;
      timeout_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      edge_cnt_reg  <= edge_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      samp_reg      <= samp_next;
      shift_reg     <= shift_next;
      par_bad_reg   <= par_bad_next;
      presc_reg     <= presc_next;
      par_en_reg    <= par_en_next;
      par_typ_reg   <= par_typ_next;
      low_reg       <= low_next;
      half_reg      <= half_next;
      byte_out_reg  <= byte_out_next;
      word_out_reg  <= word_out_next;
      frame_cnt_reg <= frame_cnt_next;
      byte_vld_reg  <= byte_vld_next;
      word_vld_reg  <= word_vld_next;
      par_err_reg   <= par_err_next;
      stp_err_reg   <= stp_err_next;
`ifdef RESP_TIMEOUT_EN
      to_cnt_reg    <= to_cnt_next;
      timeout_reg   <= timeout_next;
`endif
    end
  end

  assign BYTE_OUT  = byte_out_reg;
  assign BYTE_VLD  = byte_vld_reg;
  assign WORD_OUT  = word_out_reg;
  assign WORD_VLD  = word_vld_reg;
  assign PAR_ERR   = par_err_reg;
  assign STP_ERR   = stp_err_reg;
  assign FRAME_CNT = frame_cnt_reg;
  assign BUSY      = (state_reg != IDLE);
`ifdef RESP_TIMEOUT_EN
  assign TIMEOUT   = timeout_reg;
`endif

endmodule

// File: tb/tb_uart_resp_collector.sv
`timescale 1ns/1ps
// Bench for uart_resp_collector: vector table, hand-written corner sequences and a randomized run
// against a frame-level reference model (expected results derived from the frame rules).
module tb_uart_resp_collector;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RX_IN = 1'b1;
  logic        PAR_EN = 1'b0;
  logic        PAR_TYP = 1'b0;
  logic [5:0]  PRESCALE = 6'd8;
  logic        WORD_MODE = 1'b0;
  logic [7:0]  BYTE_OUT;
  logic        BYTE_VLD;
  logic [15:0] WORD_OUT;
  logic        WORD_VLD;
  logic        PAR_ERR;
  logic        STP_ERR;
  logic [7:0]  FRAME_CNT;
  logic        BUSY;
  logic        to_pulse;
`ifdef RESP_TIMEOUT_EN
  logic        TIMEOUT;
  assign to_pulse = TIMEOUT;
`else
  assign to_pulse = 1'b0;
`endif

  always #5 CLK = ~CLK;

  uart_resp_collector #(
    .DATA_WIDTH(8),
    .WORD_WIDTH(16),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .PRESCALE(PRESCALE),
    .WORD_MODE(WORD_MODE),
    .BYTE_OUT(BYTE_OUT),
    .BYTE_VLD(BYTE_VLD),
    .WORD_OUT(WORD_OUT),
    .WORD_VLD(WORD_VLD),
    .PAR_ERR(PAR_ERR),
    .STP_ERR(STP_ERR),
    .FRAME_CNT(FRAME_CNT),
`ifdef RESP_TIMEOUT_EN
    .TIMEOUT(TIMEOUT),
`endif
    .BUSY(BUSY)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: counts pulses, sampled on the falling edge.
  int n_byte = 0, n_word = 0, n_perr = 0, n_serr = 0, n_to = 0, n_busy = 0, cyc = 0;
  int byte_cyc = 0, to_cyc = 0;
  logic [15:0] last_word = '0;
  always @(negedge CLK) begin
    cyc++;
    if (BUSY) n_busy++;
    if (BYTE_VLD) begin
      n_byte++;
      byte_cyc = cyc;
      check("byte_vld_without_err", {30'd0, PAR_ERR, STP_ERR}, 32'd0);
    end
    if (PAR_ERR) n_perr++;
    if (STP_ERR) n_serr++;
    if (to_pulse) begin
      n_to++;
      to_cyc = cyc;
    end
    if (WORD_VLD) begin
      n_word++;
      last_word = WORD_OUT;
      check("word_vld_aligned", {31'd0, BYTE_VLD | to_pulse}, 32'd1);
    end
  end

  int s_byte, s_word, s_perr, s_serr, s_to, s_busy;
  task automatic snap();
    s_byte = n_byte; s_word = n_word; s_perr = n_perr;
    s_serr = n_serr; s_to = n_to; s_busy = n_busy;
  endtask

  task automatic check_counts(input string tag, input int vld, input int perr, input int serr,
                              input int word);
    check({tag, "_byte_vld"}, n_byte - s_byte, vld);
    check({tag, "_par_err"}, n_perr - s_perr, perr);
    check({tag, "_stp_err"}, n_serr - s_serr, serr);
    check({tag, "_word_vld"}, n_word - s_word, word);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic drive(input logic v, input int n);
    RX_IN = v;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  function automatic int eff_presc(input logic [5:0] p);
    if (p == 6'd16) return 16;
    if (p == 6'd32) return 32;
    return 8;
  endfunction

  // Drives one frame; with scramble set, the configuration inputs are changed once the start bit
  // is well under way so that only the values present at the start edge may matter.
  task automatic send_frame(input logic [7:0] data, input logic [5:0] presc_in, input logic pe,
                            input logic pt, input logic flip_par, input logic stop_bit,
                            input logic scramble);
    int p;
    logic pbit;
    p = eff_presc(presc_in);
    PRESCALE = presc_in;
    PAR_EN = pe;
    PAR_TYP = pt;
    pbit = (^data) ^ pt ^ flip_par;
    drive(1'b0, 4);
    if (scramble) begin
      PRESCALE = 6'($urandom_range(0, 63));
      PAR_EN = ~pe;
      PAR_TYP = ~pt;
    end
    drive(1'b0, p - 4);
    for (int i = 0; i < 8; i++) drive(data[i], p);
    if (pe) drive(pbit, p);
    drive(stop_bit, p);
    RX_IN = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [5:0] presc;
    logic       pe;
    logic       pt;
    logic       flip;
    logic       stop;
    int         vld;
    int         perr;
    int         serr;
    logic [7:0] byte_exp;
    logic [7:0] fc_exp;
  } vec_t;

  vec_t vecs[8];

  // Reference model state
  logic [7:0]  m_fc;
  logic [7:0]  m_byte;
  logic [7:0]  m_low;
  logic        m_half;

  initial begin : watchdog
    #(900_000);
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0]  d;
    logic [5:0]  pin;
    logic        pe, pt, flip, stp, wm, good, exp_perr, exp_word;
    logic [15:0] exp_wv;
    logic [5:0]  presc_opts [6];
    int          gap;

    vecs[0] = '{8'hA5, 6'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hA5, 8'd1};
    vecs[1] = '{8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 0, 8'hA5, 8'd1};
    vecs[2] = '{8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h3C, 8'd2};
    vecs[3] = '{8'h81, 6'd32, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, 8'h81, 8'd3};
    vecs[4] = '{8'hFF, 6'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hFF, 8'd4};
    vecs[5] = '{8'h00, 6'd8,  1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 1, 8'hFF, 8'd4};
    vecs[6] = '{8'h5A, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'hFF, 8'd4};
    vecs[7] = '{8'hC3, 6'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hC3, 8'd5};
    presc_opts[0] = 6'd8;  presc_opts[1] = 6'd16; presc_opts[2] = 6'd32;
    presc_opts[3] = 6'd12; presc_opts[4] = 6'd0;  presc_opts[5] = 6'd40;

    // Reset state
    RST = 1'b1;
    repeat (4) begin @(posedge CLK); #1; end
    check("rst_byte_out", BYTE_OUT, 0);
    check("rst_word_out", WORD_OUT, 0);
    check("rst_frame_cnt", FRAME_CNT, 0);
    check("rst_pulses", {BYTE_VLD, WORD_VLD, PAR_ERR, STP_ERR, to_pulse}, 0);
    check("rst_busy", BUSY, 0);
    RST = 1'b0;
    idle(4);

    // Table-driven single frames
    for (int i = 0; i < 8; i++) begin
      snap();
      send_frame(vecs[i].data, vecs[i].presc, vecs[i].pe, vecs[i].pt, vecs[i].flip,
                 vecs[i].stop, 1'b1);
      idle(8);
      $display("vec %0d: data=%02h presc=%0d pe=%0b pt=%0b flip=%0b stop=%0b -> byte=%02h cnt=%0d",
               i, vecs[i].data, vecs[i].presc, vecs[i].pe, vecs[i].pt, vecs[i].flip,
               vecs[i].stop, BYTE_OUT, FRAME_CNT);
      check_counts($sformatf("vec%0d", i), vecs[i].vld, vecs[i].perr, vecs[i].serr, 0);
      check($sformatf("vec%0d_byte_out", i), BYTE_OUT, vecs[i].byte_exp);
      check($sformatf("vec%0d_frame_cnt", i), FRAME_CNT, vecs[i].fc_exp);
    end
    m_fc = 8'd5;
    m_byte = 8'hC3;
    m_half = 1'b0;

    // Back-to-back pair in word mode
    WORD_MODE = 1'b1;
    snap();
    send_frame(8'h34, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h12, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    $display("pair 34,12: word=%04h byte=%02h", WORD_OUT, BYTE_OUT);
    check_counts("pair", 2, 0, 0, 1);
    check("pair_word_out", last_word, 16'h1234);
    check("pair_byte_out", BYTE_OUT, 8'h12);
    check("pair_frame_cnt", FRAME_CNT, 8'd7);
    m_fc = 8'd7;
    m_byte = 8'h12;
    WORD_MODE = 1'b0;

    // Start glitches: 2 cycles low at PRESCALE=8, 3 cycles low at PRESCALE=16
    PRESCALE = 6'd8;
    snap();
    drive(1'b0, 2);
    idle(30);
    $display("glitch P=8: busy=%0b", BUSY);
    check("glitch8_busy_seen", (n_busy - s_busy) > 0, 1);
    check("glitch8_busy_low", BUSY, 0);
    check_counts("glitch8", 0, 0, 0, 0);
    PRESCALE = 6'd16;
    snap();
    drive(1'b0, 3);
    idle(40);
    $display("glitch P=16: busy=%0b", BUSY);
    check("glitch16_busy_low", BUSY, 0);
    check_counts("glitch16", 0, 0, 0, 0);

    // Stop error, then reset mid-frame, then a clean frame
    snap();
    send_frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    $display("frame 55 bad stop: stp_err count=%0d", n_serr - s_serr);
    check_counts("stoperr", 0, 0, 1, 0);
    check("stoperr_frame_cnt", FRAME_CNT, m_fc);
    PRESCALE = 6'd8;
    drive(1'b0, 8);
    drive(1'b1, 8);
    drive(1'b0, 8);
    drive(1'b1, 4);
    check("midframe_busy", BUSY, 1);
    RST = 1'b1;
    RX_IN = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    $display("mid-frame reset: byte=%02h cnt=%0d busy=%0b", BYTE_OUT, FRAME_CNT, BUSY);
    check("mrst_byte_out", BYTE_OUT, 0);
    check("mrst_word_out", WORD_OUT, 0);
    check("mrst_frame_cnt", FRAME_CNT, 0);
    check("mrst_busy", BUSY, 0);
    check("mrst_pulses", {BYTE_VLD, WORD_VLD, PAR_ERR, STP_ERR, to_pulse}, 0);
    RST = 1'b0;
    idle(6);
    snap();
    send_frame(8'h01, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    $display("frame 01 after reset: byte=%02h cnt=%0d", BYTE_OUT, FRAME_CNT);
    check_counts("post_rst", 1, 0, 0, 0);
    check("post_rst_byte_out", BYTE_OUT, 8'h01);
    check("post_rst_frame_cnt", FRAME_CNT, 8'd1);
    m_fc = 8'd1;
    m_byte = 8'h01;

`ifdef RESP_TIMEOUT_EN
    // Lone byte in word mode is flushed as {00,byte}
    WORD_MODE = 1'b1;
    snap();
    send_frame(8'h7E, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 300 && n_to == s_to; k++) begin @(posedge CLK); #1; end
    idle(2);
    $display("timeout flush: word=%04h after %0d cycles", last_word, to_cyc - byte_cyc);
    check("timeout_seen", n_to - s_to, 1);
    check("timeout_word_vld", n_word - s_word, 1);
    check("timeout_word_out", last_word, 16'h007E);
    check("timeout_latency_ok", (to_cyc - byte_cyc) >= 63 && (to_cyc - byte_cyc) <= 65, 1);
    m_fc = m_fc + 8'd1;
    m_byte = 8'h7E;
    WORD_MODE = 1'b0;
`endif

    // Break: line held low for several frame times gives one stop error
    PRESCALE = 6'd8;
    snap();
    drive(1'b0, 240);
    $display("break: stp_err count=%0d busy=%0b", n_serr - s_serr, BUSY);
    check("break_busy_low", BUSY, 0);
    idle(20);
    check_counts("break", 0, 0, 1, 0);
    check("break_frame_cnt", FRAME_CNT, m_fc);

    // Randomized frames against the reference model
    m_half = 1'b0;
    for (int i = 0; i < 60; i++) begin
      d    = 8'($urandom_range(0, 255));
      pin  = presc_opts[$urandom_range(0, 5)];
      pe   = 1'($urandom_range(0, 1));
      pt   = 1'($urandom_range(0, 1));
      flip = ($urandom_range(0, 4) == 0);
      stp  = ($urandom_range(0, 5) != 0);
      wm   = 1'($urandom_range(0, 1));
      gap  = $urandom_range(8, 20);
      exp_perr = pe && flip;
      good = !exp_perr && stp;
      exp_word = 1'b0;
      exp_wv = '0;
      if (good) begin
        m_fc = m_fc + 8'd1;
        m_byte = d;
        if (wm) begin
          if (m_half) begin
            exp_word = 1'b1;
            exp_wv = {d, m_low};
            m_half = 1'b0;
          end else begin
            m_low = d;
            m_half = 1'b1;
          end
        end else begin
          m_half = 1'b0;
        end
      end else begin
        m_half = 1'b0;
      end
      WORD_MODE = wm;
      snap();
      send_frame(d, pin, pe, pt, flip, stp, 1'b1);
      idle(gap);
      $display("rand %0d: data=%02h presc=%0d pe=%0b pt=%0b flip=%0b stop=%0b wm=%0b -> byte=%02h word=%04h cnt=%0d",
               i, d, pin, pe, pt, flip, stp, wm, BYTE_OUT, last_word, FRAME_CNT);
      check_counts($sformatf("rand%0d", i), int'(good), int'(exp_perr), int'(!stp), int'(exp_word));
      check($sformatf("rand%0d_byte_out", i), BYTE_OUT, m_byte);
      check($sformatf("rand%0d_frame_cnt", i), FRAME_CNT, m_fc);
      if (exp_word) check($sformatf("rand%0d_word_out", i), last_word, exp_wv);
    end

    // Frame counter wrap 255 -> 0
    WORD_MODE = 1'b0;
    for (int k = 0; k < 300 && m_fc != 8'd255; k++) begin
      send_frame(8'($urandom_range(0, 255)), 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      m_fc = m_fc + 8'd1;
    end
    idle(6);
    check("wrap_at_255", FRAME_CNT, 8'd255);
    snap();
    send_frame(8'hE7, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    $display("wrap frame E7: cnt=%0d byte=%02h", FRAME_CNT, BYTE_OUT);
    check_counts("wrap", 1, 0, 0, 0);
    check("wrap_to_0", FRAME_CNT, 8'd0);
    check("wrap_byte_out", BYTE_OUT, 8'hE7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
